tube_fifo_channel: RTL and testbench
====================================

TUBE_FIFO_CHANNEL -- requirements
Module: tube_fifo_channel

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits, minimum 1.
REQ-002 SHALL have parameter DEPTH, default 24: FIFO capacity in words, minimum 2; DEPTH need not be a power of two.
REQ-003 SHALL have parameter THRESH, default 2: word count required for availability in block mode; legal range 1..DEPTH.
REQ-004 SHALL have port HO2, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port HRST, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port FLUSH, input, 1 bit: synchronous soft reset; empties the FIFO and clears error flags.
REQ-007 SHALL have port BLOCK_MODE, input, 1 bit: 1 selects THRESH-word availability; 0 selects single-word availability.
REQ-008 SHALL have port IRQ_EN, input, 1 bit: interrupt enable.
REQ-009 SHALL have port WR_STB, input, 1 bit: one-cycle write request.
REQ-010 SHALL have port WR_DATA, input, WIDTH bits: write data.
REQ-011 SHALL have port RD_STB, input, 1 bit: one-cycle read (pop) request.
REQ-012 SHALL have port RD_DATA, output, WIDTH bits: head word (show-ahead).
REQ-013 SHALL have port COUNT, output, clog2(DEPTH+1) bits: current occupancy.
REQ-014 SHALL have port AVAIL, output, 1 bit: data available to reader (status bit 7 semantics).
REQ-015 SHALL have port NOT_FULL, output, 1 bit: room for writer (status bit 6 semantics).
REQ-016 SHALL have port IRQ, output, 1 bit: level interrupt to reader.
REQ-017 SHALL have port OVF, output, 1 bit: sticky overflow flag.
REQ-018 SHALL have port UNF, output, 1 bit: sticky underflow flag.

Function
REQ-019 SHALL implement a circular buffer of DEPTH words; read and write pointers SHALL each wrap from DEPTH-1 to 0.
REQ-020 SHALL evaluate WR_STB and RD_STB against the COUNT value at the start of the cycle.
REQ-021 SHALL, on WR_STB with COUNT<DEPTH, store WR_DATA at the write pointer and advance the pointer; on WR_STB with COUNT=DEPTH, drop the write and set OVF.
REQ-022 SHALL, on RD_STB with COUNT>0, advance the read pointer; on RD_STB with COUNT=0, leave the pointer unchanged and set UNF.
REQ-023 SHALL, on simultaneous accepted read and write, leave COUNT unchanged; when full, a simultaneous read is accepted and the write is dropped with OVF set; when empty, the write is accepted and the read flags UNF.
REQ-024 SHALL drive RD_DATA combinationally from the entry at the read pointer when COUNT>0, and drive all zeros when COUNT=0.
REQ-025 SHALL, with BLOCK_MODE=0, drive AVAIL = (COUNT>=1) and NOT_FULL = (COUNT<DEPTH).
REQ-026 SHALL, with BLOCK_MODE=1, drive AVAIL = (COUNT>=THRESH) and NOT_FULL = (COUNT<=DEPTH-THRESH).
REQ-027 SHALL derive AVAIL, NOT_FULL and COUNT combinationally from registered state, so they update in the cycle after the causing strobe edge.
REQ-028 SHALL drive IRQ = IRQ_EN AND AVAIL.
REQ-029 SHALL, while FLUSH=1, zero COUNT and both pointers and clear OVF and UNF each cycle, ignoring WR_STB and RD_STB; FLUSH SHALL take priority over strobes.
REQ-030 SHALL, when BLOCK_MODE changes, leave FIFO contents intact and re-evaluate the flags from the current COUNT immediately.
REQ-031 SHALL hold OVF and UNF set until FLUSH or HRST.

Reset
REQ-032 SHALL, while HRST=1 and regardless of HO2, hold COUNT=0, pointers=0, OVF=0, UNF=0, giving RD_DATA=0, AVAIL=0, NOT_FULL=1 and IRQ=0.
REQ-033 SHALL not require storage array contents to be reset; no stale word SHALL be visible after reset.
REQ-034 SHALL, on HRST asserting mid-transfer, discard all data and abort any strobe in that cycle.

Verification
REQ-035 Default parameters, BLOCK_MODE=0: write 24 words 170..193 -> after the 1st write AVAIL=1; after the 24th, NOT_FULL=0 and COUNT=24; 24 reads return 170..193 in order; final AVAIL=0, NOT_FULL=1.
REQ-036 DEPTH=2, THRESH=2, BLOCK_MODE=1: write 0xAA -> AVAIL=0, NOT_FULL=0; write 0xAB -> AVAIL=1; reads return 0xAA then 0xAB; final AVAIL=0, NOT_FULL=1.
REQ-037 Full FIFO plus a 25th write -> word dropped and OVF=1; read on empty FIFO -> UNF=1; FLUSH for 1 cycle -> COUNT=0, OVF=0, UNF=0.
REQ-038 Wrap and concurrency: push 20 words, pop 20, then push 10 with a simultaneous read/write each cycle -> data order preserved across the pointer wrap and COUNT remains constant.
REQ-039 IRQ_EN=1, BLOCK_MODE=0: first write -> IRQ=1 on the next cycle; pop to empty -> IRQ=0; HRST pulse mid-burst -> all outputs reach their REQ-032 values asynchronously.

Source files
------------

// File: rtl/tube_fifo_channel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tube_fifo_channel: DEPTH-word show-ahead FIFO channel with block-mode    |
// | availability, level IRQ and sticky overflow/underflow flags.  Rev 1.0    |
// +--------------------------------------------------------------------------+
module tube_fifo_channel #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 24,
  parameter int THRESH = 2
) (
  input  logic                       HO2,
  input  logic                       HRST,
  input  logic                       FLUSH,
  input  logic                       BLOCK_MODE,
  input  logic                       IRQ_EN,
  input  logic                       WR_STB,
  input  logic [WIDTH-1:0]           WR_DATA,
  input  logic                       RD_STB,
  output logic [WIDTH-1:0]           RD_DATA,
  output logic [$clog2(DEPTH+1)-1:0] COUNT,
  output logic                       AVAIL,
  output logic                       NOT_FULL,
  output logic                       IRQ,
  output logic                       OVF,
  output logic                       UNF
);

  localparam int c_cnt_w = $clog2(DEPTH+1);
  localparam int c_ptr_w = $clog2(DEPTH);
  localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(DEPTH-1);
  localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_thresh   = c_cnt_w'(THRESH);
  localparam logic [c_cnt_w-1:0] c_room_max = c_cnt_w'(DEPTH-THRESH);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_cnt_w-1:0] count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               wr_ok, rd_ok, mem_we;

  always_comb begin
    wr_ok    = WR_STB && (count_q != c_depth);
    rd_ok    = RD_STB && (count_q != '0);
    mem_we   = wr_ok && !FLUSH;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_ok) wr_ptr_d = (wr_ptr_q == c_ptr_last) ? '0 : wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_d = (rd_ptr_q == c_ptr_last) ? '0 : rd_ptr_q + 1'b1;
      count_d = count_q + c_cnt_w'(wr_ok) - c_cnt_w'(rd_ok);
      if (WR_STB && !wr_ok) ovf_d = 1'b1;
      if (RD_STB && !rd_ok) unf_d = 1'b1;
    end
  end

  always_ff @(posedge HO2 or posedge HRST) begin
    if (HRST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage is never reset; the zero-count gate on RD_DATA hides stale words.
  always_ff @(posedge HO2) begin
    if (mem_we && !HRST) mem_q[wr_ptr_q] <= WR_DATA;
  end

  always_comb begin
    RD_DATA  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    COUNT    = count_q;
    AVAIL    = BLOCK_MODE ? (count_q >= c_thresh)   : (count_q != '0);
    NOT_FULL = BLOCK_MODE ? (count_q <= c_room_max) : (count_q != c_depth);
    IRQ      = IRQ_EN && AVAIL;
    OVF      = ovf_q;
    UNF      = unf_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_tube_fifo_channel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tube_fifo_channel: randomized bench against a queue-based model.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_tube_fifo_channel;

  localparam int DEPTH  = 24;
  localparam int THRESH = 2;

  logic       clk;
  logic       hrst, flush, block_mode, irq_en, wr_stb, rd_stb;
  logic [7:0] wr_data, rd_data;
  logic [4:0] count;
  logic       avail, not_full, irq, ovf, unf;

  logic       s_wr, s_rd;
  logic [7:0] s_wd, s_rdata;
  logic [1:0] s_count;
  logic       s_avail, s_nf, s_irq, s_ovf, s_unf;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] q [$];
  bit         m_ovf, m_unf;

  tube_fifo_channel #(.WIDTH(8), .DEPTH(DEPTH), .THRESH(THRESH)) dut (
    .HO2(clk), .HRST(hrst), .FLUSH(flush), .BLOCK_MODE(block_mode),
    .IRQ_EN(irq_en), .WR_STB(wr_stb), .WR_DATA(wr_data), .RD_STB(rd_stb),
    .RD_DATA(rd_data), .COUNT(count), .AVAIL(avail), .NOT_FULL(not_full),
    .IRQ(irq), .OVF(ovf), .UNF(unf)
  );

  tube_fifo_channel #(.WIDTH(8), .DEPTH(2), .THRESH(2)) dut_small (
    .HO2(clk), .HRST(hrst), .FLUSH(1'b0), .BLOCK_MODE(1'b1),
    .IRQ_EN(1'b0), .WR_STB(s_wr), .WR_DATA(s_wd), .RD_STB(s_rd),
    .RD_DATA(s_rdata), .COUNT(s_count), .AVAIL(s_avail), .NOT_FULL(s_nf),
    .IRQ(s_irq), .OVF(s_ovf), .UNF(s_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    int  n;
    bit  e_avail, e_nf;
    n       = q.size();
    e_avail = block_mode ? (n >= THRESH) : (n >= 1);
    e_nf    = block_mode ? (n <= DEPTH - THRESH) : (n < DEPTH);
    check({tag, ".count"},    32'(count),    32'(n));
    check({tag, ".rd_data"},  32'(rd_data),  (n > 0) ? 32'(q[0]) : 32'd0);
    check({tag, ".avail"},    32'(avail),    32'(e_avail));
    check({tag, ".not_full"}, 32'(not_full), 32'(e_nf));
    check({tag, ".irq"},      32'(irq),      32'(irq_en & e_avail));
    check({tag, ".ovf"},      32'(ovf),      32'(m_ovf));
    check({tag, ".unf"},      32'(unf),      32'(m_unf));
  endtask

  // Applies one cycle of stimulus, advances the model, then checks after the edge.
  task automatic cycle(input string tag, input bit wr, input logic [7:0] wd,
                       input bit rd, input bit fl);
    bit wr_ok, rd_ok;
    wr_stb = wr; wr_data = wd; rd_stb = rd; flush = fl;
    @(posedge clk);
    if (fl) begin
      q.delete(); m_ovf = 0; m_unf = 0;
    end else begin
      wr_ok = wr && (q.size() < DEPTH);
      rd_ok = rd && (q.size() > 0);
      if (rd_ok) void'(q.pop_front());
      if (wr_ok) q.push_back(wd);
      if (wr && !wr_ok) m_ovf = 1;
      if (rd && !rd_ok) m_unf = 1;
    end
    #1;
    wr_stb = 0; rd_stb = 0; flush = 0;
    check_all(tag);
  endtask

  initial begin
    hrst = 1; flush = 0; block_mode = 0; irq_en = 0;
    wr_stb = 0; rd_stb = 0; wr_data = 8'h00;
    s_wr = 0; s_rd = 0; s_wd = 8'h00;
    m_ovf = 0; m_unf = 0;
    #12;
    check_all("reset");
    @(posedge clk); #1;
    check_all("reset_clk");
    hrst = 0;

    // Fill with 170..193, then drain in order.
    for (int i = 0; i < DEPTH; i++) cycle("fill", 1, 8'(170 + i), 0, 0);
    check("full.count", 32'(count), 32'd24);
    cycle("ovf_write", 1, 8'hEE, 0, 0);
    check("ovf.flag", 32'(ovf), 32'd1);
    block_mode = 1; #1; check_all("bm_on_full");
    block_mode = 0; #1; check_all("bm_off_full");
    cycle("full_rw", 1, 8'h55, 1, 0);
    cycle("drain_one", 0, 8'h00, 1, 0);
    for (int i = 0; i < DEPTH - 2; i++) cycle("drain", 0, 8'h00, 1, 0);
    cycle("unf_read", 0, 8'h00, 1, 0);
    check("unf.flag", 32'(unf), 32'd1);
    cycle("empty_rw", 1, 8'h3C, 1, 0);
    cycle("flush", 1, 8'h11, 1, 1);
    check("flush.count", 32'(count), 32'd0);

    // Wrap with concurrent traffic.
    for (int i = 0; i < 20; i++) cycle("wrap_push", 1, 8'($urandom), 0, 0);
    for (int i = 0; i < 20; i++) cycle("wrap_pop", 0, 8'h00, 1, 0);
    for (int i = 0; i < 4; i++)  cycle("wrap_pre", 1, 8'(i + 1), 0, 0);
    for (int i = 0; i < 10; i++) begin
      cycle("wrap_rw", 1, 8'(100 + i), 1, 0);
      check("wrap_rw.const", 32'(count), 32'd4);
    end
    cycle("flush2", 0, 8'h00, 0, 1);

    // IRQ behaviour.
    irq_en = 1;
    cycle("irq_wr", 1, 8'h42, 0, 0);
    check("irq.set", 32'(irq), 32'd1);
    cycle("irq_rd", 0, 8'h00, 1, 0);
    check("irq.clr", 32'(irq), 32'd0);

    // Randomized traffic with mode changes and rare flushes.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        block_mode = ~block_mode; #1; check_all("rnd_bm");
      end
      irq_en = 1'($urandom);
      cycle("rnd", $urandom_range(0, 9) < 6, 8'($urandom),
            $urandom_range(0, 9) < 5, $urandom_range(0, 59) == 0);
    end

    // Asynchronous reset in the middle of a write burst.
    block_mode = 0; irq_en = 1;
    for (int i = 0; i < 5; i++) cycle("burst", 1, 8'(i + 9), 0, 0);
    wr_stb = 1; wr_data = 8'h77; rd_stb = 0;
    #2 hrst = 1;
    q.delete(); m_ovf = 0; m_unf = 0;
    #1; check_all("hrst_async");
    @(posedge clk); #1;
    check_all("hrst_hold");
    hrst = 0; wr_stb = 0;
    #1; check_all("hrst_release");

    // DEPTH=2, THRESH=2 block-mode instance.
    s_wr = 1; s_wd = 8'hAA; @(posedge clk); #1; s_wr = 0;
    check("s.aa.avail", 32'(s_avail), 32'd0);
    check("s.aa.nf",    32'(s_nf),    32'd0);
    check("s.aa.count", 32'(s_count), 32'd1);
    s_wr = 1; s_wd = 8'hAB; @(posedge clk); #1; s_wr = 0;
    check("s.ab.avail", 32'(s_avail), 32'd1);
    check("s.ab.head",  32'(s_rdata), 32'hAA);
    s_rd = 1; @(posedge clk); #1; s_rd = 0;
    check("s.rd1.head", 32'(s_rdata), 32'hAB);
    check("s.rd1.avail", 32'(s_avail), 32'd0);
    s_rd = 1; @(posedge clk); #1; s_rd = 0;
    check("s.rd2.avail", 32'(s_avail), 32'd0);
    check("s.rd2.nf",    32'(s_nf),    32'd1);
    check("s.rd2.data",  32'(s_rdata), 32'd0);
    check("s.flags",     32'({s_ovf, s_unf, s_irq}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
